// File: rtl/dm_scan_mux.sv
// dm_scan_mux - time-multiplexed N-digit hex 7-segment display driver.
//
// Scans N_DIGITS hex digits onto a shared active-low cathode bus, one digit
// per slot of SLOT_CYCLES clocks. The first BLANK_CYCLES of each slot keep all
// anodes off so the previous digit's segments never ghost into the next one.
// Inputs are double-buffered: nothing on the input pins reaches the display
// until a load strobe copies them into shadow registers.
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   digit_data  4 bits per digit, digit 0 (rightmost) in [3:0]
//   digit_en    per-digit enable
//   dp          per-digit decimal point
//   blink       per-digit blink request
//   lz_en       leading-zero suppression enable
//   load        strobe that captures the five inputs above into the shadows
//   an          anodes, active-low, at most one bit low
//   dec_cat     cathodes, active-low, [7:1] = segments a..g, [0] = dp

module dm_scan_mux #(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digit_data,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            dec_cat
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  logic [4*N_DIGITS-1:0] data_sh;
  logic [N_DIGITS-1:0]   en_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [N_DIGITS-1:0]   blink_sh;
  logic                  lz_sh;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame;
  logic          blink_phase;

  logic [N_DIGITS-1:0] supp;
  logic                zero_run;
  logic [3:0]          cur_val;
  logic                visible;
  logic                slot_wrap;
  logic                last_digit;
  logic                blanking;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  // Suppression runs from the most significant digit downwards and stops at
  // the first digit that is non-zero and enabled, or that carries a dp.
  // Digit 0 is never suppressed so a zero value still shows "0".
  always_comb begin
    supp     = '0;
    zero_run = lz_sh;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && ((data_sh[4*i +: 4] == 4'h0) || !en_sh[i]) && !dp_sh[i];
      supp[i]  = zero_run;
    end
  end

  assign cur_val    = data_sh[{idx, 2'b00} +: 4];
  assign visible    = en_sh[idx] && !supp[idx] && !(blink_sh[idx] && blink_phase);
  assign slot_wrap  = (presc == PW'(SLOT_CYCLES - 1));
  assign last_digit = (idx == IW'(N_DIGITS - 1));
  assign blanking   = (presc < PW'(BLANK_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_sh     <= '0;
      en_sh       <= '0;
      dp_sh       <= '0;
      blink_sh    <= '0;
      lz_sh       <= 1'b0;
      presc       <= '0;
      idx         <= '0;
      frame       <= '0;
      blink_phase <= 1'b0;
      an          <= '1;
      dec_cat     <= 8'hFF;
    end else begin
      if (load) begin
        data_sh  <= digit_data;
        en_sh    <= digit_en;
        dp_sh    <= dp;
        blink_sh <= blink;
        lz_sh    <= lz_en;
      end

      if (slot_wrap) begin
        presc <= '0;
        if (last_digit) begin
          idx <= '0;
          if (frame == FW'(BLINK_FRAMES - 1)) begin
            frame       <= '0;
            blink_phase <= !blink_phase;
          end else begin
            frame <= frame + FW'(1);
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        presc <= presc + PW'(1);
      end

      // Outputs follow the current slot position one clock later.
      if (blanking || !visible) begin
        an      <= '1;
        dec_cat <= 8'hFF;
      end else begin
        an      <= ~(ONE_HOT0 << idx);
        dec_cat <= {~seg7(cur_val), ~dp_sh[idx]};
      end
    end
  end

endmodule

// File: tb/tb_dm_scan_mux.sv
// Directed bench for dm_scan_mux with 4 digits, 4-cycle slots, 1 blank
// cycle and 2-frame blink half-period. cyc counts rising edges since the
// last reset release; the output sampled after edge k belongs to slot
// position (k-1) mod 16, i.e. digit (k-1)/4 mod 4, cycle (k-1) mod 4.

module tb_dm_scan_mux;

  logic        clock;
  logic        reset;
  logic [15:0] digit_data;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic        lz_en;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  dec_cat;

  int n_checks;
  int n_fail;
  int cyc;

  dm_scan_mux #(
    .N_DIGITS    (4),
    .SLOT_CYCLES (4),
    .BLANK_CYCLES(1),
    .BLINK_FRAMES(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .digit_data(digit_data),
    .digit_en  (digit_en),
    .dp        (dp),
    .blink     (blink),
    .lz_en     (lz_en),
    .load      (load),
    .an        (an),
    .dec_cat   (dec_cat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic goto(input int d, input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((((cyc - 1) % 16) != d * 4 + p) && n < 40);
    n_checks++;
    if (((cyc - 1) % 16) != d * 4 + p) begin
      n_fail++;
      $display("FAIL goto: slot position %0d, wanted %0d", (cyc - 1) % 16, d * 4 + p);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p,
                         input logic [3:0] b, input logic lz);
    digit_data = d;
    digit_en   = e;
    dp         = p;
    blink      = b;
    lz_en      = lz;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (an !== 4'b1111) begin
      n_fail++; $display("FAIL reset_an: got %b want 1111", an);
    end
    n_checks++;
    if (dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL reset_cat: got %h want ff", dec_cat);
    end
    reset = 1'b1;
    cyc   = 0;
    // shadows are clear, so the display stays dark
    goto(0, 2);
    n_checks++;
    if (an !== 4'b1111) begin
      n_fail++; $display("FAIL reset_dark: got %b want 1111", an);
    end
  endtask

  task automatic test_basic();
    logic [3:0] an_tab[4];
    logic [7:0] cat_tab[4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    cat_tab = '{8'h99, 8'h0D, 8'h25, 8'h9F};
    do_load(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        goto(d, 0);
        n_checks++;
        if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
          n_fail++; $display("FAIL basic_blank d%0d: an=%b cat=%h want 1111/ff", d, an, dec_cat);
        end
        goto(d, 1);
        n_checks++;
        if (an !== an_tab[d] || dec_cat !== cat_tab[d]) begin
          n_fail++; $display("FAIL basic_lit d%0d: an=%b cat=%h want %b/%h", d, an, dec_cat, an_tab[d], cat_tab[d]);
        end
        goto(d, 3);
        n_checks++;
        if (an !== an_tab[d] || dec_cat !== cat_tab[d]) begin
          n_fail++; $display("FAIL basic_end d%0d: an=%b cat=%h want %b/%h", d, an, dec_cat, an_tab[d], cat_tab[d]);
        end
      end
    end
  endtask

  task automatic test_no_load();
    digit_data = 16'h5678;
    goto(0, 1);
    n_checks++;
    if (an !== 4'b1110 || dec_cat !== 8'h99) begin
      n_fail++; $display("FAIL noload_d0: an=%b cat=%h want 1110/99", an, dec_cat);
    end
    goto(3, 2);
    n_checks++;
    if (an !== 4'b0111 || dec_cat !== 8'h9F) begin
      n_fail++; $display("FAIL noload_d3: an=%b cat=%h want 0111/9f", an, dec_cat);
    end
    do_load(16'h123A, 4'hF, 4'h0, 4'h0, 1'b0);
    goto(0, 2);
    n_checks++;
    if (an !== 4'b1110 || dec_cat !== 8'h11) begin
      n_fail++; $display("FAIL load_new: an=%b cat=%h want 1110/11", an, dec_cat);
    end
  endtask

  task automatic test_lz();
    do_load(16'h0050, 4'hF, 4'h0, 4'h0, 1'b1);
    goto(1, 1);
    n_checks++;
    if (an !== 4'b1101 || dec_cat !== 8'h49) begin
      n_fail++; $display("FAIL lz_d1: an=%b cat=%h want 1101/49", an, dec_cat);
    end
    goto(2, 1);
    n_checks++;
    if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL lz_d2: an=%b cat=%h want 1111/ff", an, dec_cat);
    end
    goto(3, 2);
    n_checks++;
    if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL lz_d3: an=%b cat=%h want 1111/ff", an, dec_cat);
    end
    goto(0, 1);
    n_checks++;
    if (an !== 4'b1110 || dec_cat !== 8'h03) begin
      n_fail++; $display("FAIL lz_d0: an=%b cat=%h want 1110/03", an, dec_cat);
    end
    do_load(16'h0050, 4'hF, 4'b0100, 4'h0, 1'b1);
    goto(2, 1);
    n_checks++;
    if (an !== 4'b1011 || dec_cat !== 8'h02) begin
      n_fail++; $display("FAIL lz_dp_d2: an=%b cat=%h want 1011/02", an, dec_cat);
    end
    goto(3, 1);
    n_checks++;
    if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL lz_dp_d3: an=%b cat=%h want 1111/ff", an, dec_cat);
    end
  endtask

  task automatic test_disabled();
    do_load(16'h1234, 4'b1011, 4'b0100, 4'h0, 1'b0);
    goto(1, 1);
    n_checks++;
    if (an !== 4'b1101 || dec_cat !== 8'h0D) begin
      n_fail++; $display("FAIL dis_d1: an=%b cat=%h want 1101/0d", an, dec_cat);
    end
    goto(2, 1);
    n_checks++;
    if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL dis_d2: an=%b cat=%h want 1111/ff", an, dec_cat);
    end
    goto(3, 1);
    n_checks++;
    if (an !== 4'b0111 || dec_cat !== 8'h9F) begin
      n_fail++; $display("FAIL dis_d3: an=%b cat=%h want 0111/9f", an, dec_cat);
    end
  endtask

  task automatic test_load_wrap();
    do_load(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    goto(0, 2);
    // next edge is the slot wrap; load on that same edge
    do_load(16'h1294, 4'hF, 4'h0, 4'h0, 1'b0);
    goto(1, 1);
    n_checks++;
    if (an !== 4'b1101 || dec_cat !== 8'h09) begin
      n_fail++; $display("FAIL load_wrap: an=%b cat=%h want 1101/09", an, dec_cat);
    end
  endtask

  task automatic test_reset_mid();
    do_load(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    goto(2, 2);
    n_checks++;
    if (an !== 4'b1011) begin
      n_fail++; $display("FAIL pre_reset: an=%b want 1011", an);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL reset_mid: an=%b cat=%h want 1111/ff", an, dec_cat);
    end
    @(negedge clock);
    reset = 1'b1;
    cyc   = 0;
    digit_data = 16'h1234;
    digit_en   = 4'hF;
    dp         = 4'h0;
    blink      = 4'h0;
    lz_en      = 1'b0;
    load       = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (an !== 4'b1111 || dec_cat !== 8'hFF) begin
      n_fail++; $display("FAIL post_reset_blank: an=%b cat=%h want 1111/ff", an, dec_cat);
    end
    tick();
    n_checks++;
    if (an !== 4'b1110 || dec_cat !== 8'h99) begin
      n_fail++; $display("FAIL post_reset_d0: an=%b cat=%h want 1110/99", an, dec_cat);
    end
  endtask

  task automatic test_blink();
    logic [3:0] want;
    do_load(16'h1234, 4'hF, 4'h0, 4'b0001, 1'b0);
    for (int f = 0; f < 8; f++) begin
      goto(0, 2);
      // blink phase flips every 32 cycles counted from reset release
      want = ((((cyc - 1) / 32) % 2) == 0) ? 4'b1110 : 4'b1111;
      n_checks++;
      if (an !== want) begin
        n_fail++; $display("FAIL blink_d0 frame %0d: an=%b want %b", f, an, want);
      end
      goto(1, 2);
      n_checks++;
      if (an !== 4'b1101 || dec_cat !== 8'h0D) begin
        n_fail++; $display("FAIL blink_d1 frame %0d: an=%b cat=%h want 1101/0d", f, an, dec_cat);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    reset      = 1'b0;
    digit_data = '0;
    digit_en   = '0;
    dp         = '0;
    blink      = '0;
    lz_en      = 1'b0;
    load       = 1'b0;
    test_reset();
    test_basic();
    test_no_load();
    test_lz();
    test_disabled();
    test_load_wrap();
    test_reset_mid();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
